dmac_aw_w_scheduler: RTL and testbench

Shared write-path scheduler between the DMAC per-channel engines and the single AXI write master port. It arbitrates AW requests round-robin, records each granted burst (master index and AWLEN) in an order FIFO, and then steers the W channel strictly in AW-grant order, one whole burst at a time. This guarantees that W data is never interleaved and never reordered relative to AW. It also flags W bursts whose beat count disagrees with AWLEN.

---
 rtl/dmac_aw_w_scheduler_if.sv | 34 +++
 rtl/dmac_aw_w_scheduler.sv | 151 +++++++++++++++
 tb/tb_dmac_aw_w_scheduler.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_aw_w_scheduler_if.sv
// AW/W bundle between the DMAC engines, the scheduler and the AXI write port.
// slave: scheduler side; master: engines plus AXI slave side (testbench).
interface dmac_aw_w_scheduler_if #(
  parameter int N_MASTER = 4,
  parameter int AW_W     = 45,
  parameter int W_W      = 41
);
  logic [N_MASTER-1:0]      src_awvalid_i;
  logic [N_MASTER-1:0]      src_awready_o;
  logic [N_MASTER*AW_W-1:0] src_awdata_i;
  logic                     awvalid_o;
  logic                     awready_i;
  logic [AW_W-1:0]          awdata_o;
  logic [N_MASTER-1:0]      src_wvalid_i;
  logic [N_MASTER-1:0]      src_wready_o;
  logic [N_MASTER*W_W-1:0]  src_wdata_i;
  logic                     wvalid_o;
  logic                     wready_i;
  logic [W_W-1:0]           wdata_o;

  modport slave (
    input  src_awvalid_i, src_awdata_i, awready_i,
    input  src_wvalid_i, src_wdata_i, wready_i,
    output src_awready_o, awvalid_o, awdata_o,
    output src_wready_o, wvalid_o, wdata_o
  );

  modport master (
    output src_awvalid_i, src_awdata_i, awready_i,
    output src_wvalid_i, src_wdata_i, wready_i,
    input  src_awready_o, awvalid_o, awdata_o,
    input  src_wready_o, wvalid_o, wdata_o
  );
endinterface

// File: rtl/dmac_aw_w_scheduler.sv
// Round-robin AW arbiter feeding an order FIFO that steers W in AW order.
// Ports: clk, rst, bus (AW/W), outstanding_o (FIFO occupancy), len_err_o.
module dmac_aw_w_scheduler #(
  parameter int N_MASTER   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AW_W       = 45,
  parameter int W_W        = 41
) (
  input  logic                        clk,
  input  logic                        rst,
  dmac_aw_w_scheduler_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0] outstanding_o,
  output logic                        len_err_o
);
  localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // awlen sits above awsize[2:0] and awburst[1:0]
  localparam int LEN_LSB = 5;

  logic [IW-1:0]   rr_ptr;
  logic            lock;
  logic [IW-1:0]   lock_idx;
  logic            cand_ok;
  logic [IW-1:0]   cand_idx;
  logic            gnt_ok;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   gnt_nxt;
  logic            awvalid;
  logic            aw_fire;
  logic [AW_W-1:0] aw_sel;

  logic [IW-1:0]   fifo_idx [FIFO_DEPTH];
  logic [3:0]      fifo_len [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic [IW-1:0]   head_idx;
  logic [3:0]      head_len;
  logic [IW-1:0]   w_idx;
  logic [W_W-1:0]  w_sel;
  logic            wvalid;
  logic            w_fire;
  logic            wlast;
  logic            push;
  logic            pop;
  logic [3:0]      beat_cnt;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_comb begin : search
    int j;
    j        = 0;
    cand_ok  = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      if (!cand_ok && bus.src_awvalid_i[IW'(j)]) begin
        cand_ok  = 1'b1;
        cand_idx = IW'(j);
      end
    end
  end

  // A pending lock overrides the search so the payload cannot move.
  assign gnt_ok  = lock | cand_ok;
  assign gnt_idx = lock ? lock_idx : cand_idx;
  assign gnt_nxt = (gnt_idx == IW'(N_MASTER - 1)) ? '0 : gnt_idx + 1'b1;

  assign awvalid = !rst && !full && gnt_ok;
  assign aw_fire = awvalid && bus.awready_i;
  assign aw_sel  = bus.src_awdata_i[gnt_idx*AW_W +: AW_W];

  assign bus.awvalid_o = awvalid;
  assign bus.awdata_o  = aw_sel;

  always_comb begin
    bus.src_awready_o = '0;
    if (awvalid) bus.src_awready_o[gnt_idx] = bus.awready_i;
  end

  assign head_idx = fifo_idx[rd_ptr];
  assign head_len = fifo_len[rd_ptr];
  assign w_idx    = empty ? '0 : head_idx;
  assign w_sel    = bus.src_wdata_i[w_idx*W_W +: W_W];
  assign wvalid   = !rst && !empty && bus.src_wvalid_i[head_idx];
  assign w_fire   = wvalid && bus.wready_i;
  assign wlast    = w_sel[0];

  assign bus.wvalid_o = wvalid;
  assign bus.wdata_o  = w_sel;

  always_comb begin
    bus.src_wready_o = '0;
    if (!rst && !empty) bus.src_wready_o[head_idx] = bus.wready_i;
  end

  assign push = aw_fire;
  assign pop  = w_fire && wlast;

  assign outstanding_o = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_idx  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      beat_cnt  <= '0;
      len_err_o <= 1'b0;
    end else begin
      if (aw_fire) begin
        rr_ptr <= gnt_nxt;
        lock   <= 1'b0;
      end else if (awvalid) begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (w_fire) begin
        if (wlast) begin
          beat_cnt <= '0;
          if (beat_cnt != head_len) len_err_o <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == head_len) len_err_o <= 1'b1;
        end
      end
    end
  end

  // Entry storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= gnt_idx;
      fifo_len[wr_ptr] <= aw_sel[LEN_LSB +: 4];
    end
  end
endmodule

// File: tb/tb_dmac_aw_w_scheduler.sv
// Self-checking bench for dmac_aw_w_scheduler: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_dmac_aw_w_scheduler;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AW = 45;
  localparam int WW = 41;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(D):0] outstanding;
  logic len_err;

  always #5 clk = ~clk;

  dmac_aw_w_scheduler_if #(.N_MASTER(N), .AW_W(AW), .W_W(WW)) bus ();

  dmac_aw_w_scheduler #(
    .N_MASTER(N), .FIFO_DEPTH(D), .AW_W(AW), .W_W(WW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .outstanding_o(outstanding),
    .len_err_o(len_err)
  );

  logic [AW-1:0] aw_pl [N];
  logic [WW-1:0] w_pl  [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.src_awdata_i[i*AW +: AW] = aw_pl[i];
    assign bus.src_wdata_i[i*WW +: WW]  = w_pl[i];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_aw(input int id, input logic [31:0] a,
                                          input logic [3:0] len);
    logic [3:0] i4;
    i4 = 4'(id);
    return {i4, a, len, 3'b010, 2'b01};
  endfunction

  function automatic logic [WW-1:0] mk_w(input int id, input logic [31:0] d,
                                         input logic last);
    logic [3:0] i4;
    i4 = 4'(id);
    return {i4, d, 4'hf, last};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.src_awvalid_i = '0;
    bus.src_wvalid_i  = '0;
    bus.awready_i     = 1'b0;
    bus.wready_i      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.src_awvalid_i = '1;
    bus.src_wvalid_i  = '1;
    bus.awready_i     = 1'b1;
    bus.wready_i      = 1'b1;
    cyc();
    chk("rst_awvalid", bus.awvalid_o, 0);
    chk("rst_wvalid", bus.wvalid_o, 0);
    chk("rst_src_awready", bus.src_awready_o, 0);
    chk("rst_src_wready", bus.src_wready_o, 0);
    cyc();
    idle();
    rst = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_len_err", len_err, 0);
  endtask

  task automatic set_aw_all(input logic [3:0] len);
    for (int i = 0; i < N; i++) aw_pl[i] = mk_aw(i, 32'h1000 * i, len);
  endtask

  typedef struct {
    logic [3:0] awv;
    logic       awr;
    logic       e_awv;
    logic [3:0] e_rdy;
    int         e_id;
    int         e_out;
  } vec_t;

  vec_t vt [7];

  typedef struct {
    int idx;
    int len;
  } ent_t;

  initial begin
    int exp_ord [3];
    ent_t m_q [$];
    int m_rr, m_lock_idx, m_beat;
    bit m_lock, m_err;
    bit aw_on [N];
    bit w_on [N];
    int aw_left [N];
    int pend_len [N];
    int wbeat [N];
    int wq [N][$];

    rst = 1'b1;
    idle();
    set_aw_all(4'd0);
    for (int i = 0; i < N; i++) w_pl[i] = mk_w(i, 32'hd000 + i, 1'b1);

    do_reset();

    // Arbitration table, applied one cycle per entry from reset.
    vt[0] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 0, 0};
    vt[1] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2, 0};
    vt[2] = '{4'b0101, 1'b0, 1'b1, 4'b0000, 0, 1};
    vt[3] = '{4'b0111, 1'b1, 1'b1, 4'b0001, 0, 1};
    vt[4] = '{4'b1100, 1'b1, 1'b1, 4'b0100, 2, 2};
    vt[5] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 0, 3};
    vt[6] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 0, 4};
    for (int v = 0; v < 7; v++) begin
      bus.src_awvalid_i = vt[v].awv;
      bus.awready_i     = vt[v].awr;
      #1;
      chk($sformatf("tbl%0d_awvalid", v), bus.awvalid_o, vt[v].e_awv);
      chk($sformatf("tbl%0d_awready", v), bus.src_awready_o, vt[v].e_rdy);
      chk($sformatf("tbl%0d_outst", v), outstanding, vt[v].e_out);
      if (vt[v].e_awv)
        chk($sformatf("tbl%0d_awid", v), bus.awdata_o[44:41], vt[v].e_id);
      cyc();
    end

    // Full FIFO {2,0,2,0}: pop-only, then simultaneous push and pop.
    bus.src_awvalid_i = 4'b0010;
    bus.awready_i     = 1'b1;
    bus.src_wvalid_i  = 4'b0100;
    bus.wready_i      = 1'b1;
    #1;
    chk("full_awvalid", bus.awvalid_o, 0);
    chk("full_wvalid", bus.wvalid_o, 1);
    chk("full_wready", bus.src_wready_o, 4'b0100);
    chk("full_wdata", bus.wdata_o, w_pl[2]);
    cyc();
    chk("pop_only_outst", outstanding, 3);
    bus.src_wvalid_i = 4'b0001;
    #1;
    chk("pushpop_awvalid", bus.awvalid_o, 1);
    chk("pushpop_awready", bus.src_awready_o, 4'b0010);
    chk("pushpop_wready", bus.src_wready_o, 4'b0001);
    cyc();
    chk("pushpop_outst", outstanding, 3);
    bus.src_awvalid_i = '0;
    bus.src_wvalid_i  = '1;
    exp_ord = '{2, 0, 1};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("drain%0d_wready", k), bus.src_wready_o, 1 << exp_ord[k]);
      cyc();
    end
    chk("drain_outst", outstanding, 0);
    chk("drain_len_err", len_err, 0);

    // Reset with a burst in flight.
    idle();
    bus.src_awvalid_i = 4'b1000;
    bus.awready_i     = 1'b1;
    cyc();
    chk("inflight_outst", outstanding, 1);
    do_reset();

    // Single master 2, awlen 3, four beats.
    aw_pl[2] = mk_aw(2, 32'h2000_0040, 4'd3);
    w_pl[2]  = mk_w(2, 32'ha0, 1'b0);
    bus.src_awvalid_i = 4'b0100;
    bus.src_wvalid_i  = 4'b0100;
    bus.awready_i     = 1'b1;
    bus.wready_i      = 1'b1;
    #1;
    chk("single_awvalid", bus.awvalid_o, 1);
    chk("single_awdata", bus.awdata_o, aw_pl[2]);
    chk("single_w_before_aw", bus.wvalid_o, 0);
    cyc();
    bus.src_awvalid_i = '0;
    for (int b = 0; b < 4; b++) begin
      w_pl[2] = mk_w(2, 32'ha0 + b, b == 3);
      #1;
      chk($sformatf("single_b%0d_outst", b), outstanding, 1);
      chk($sformatf("single_b%0d_wdata", b), bus.wdata_o, w_pl[2]);
      chk($sformatf("single_b%0d_wready", b), bus.src_wready_o, 4'b0100);
      cyc();
    end
    bus.src_wvalid_i = '0;
    #1;
    chk("single_outst_end", outstanding, 0);
    chk("single_len_err", len_err, 0);
    set_aw_all(4'd0);
    bus.src_awvalid_i = '1;
    bus.awready_i     = 1'b0;
    #1;
    chk("single_next_rr", bus.awdata_o[44:41], 3);
    do_reset();

    // Round robin with continuous requests until full.
    set_aw_all(4'd0);
    for (int i = 0; i < N; i++) w_pl[i] = mk_w(i, 32'hb0 + i, 1'b1);
    bus.src_awvalid_i = '1;
    bus.awready_i     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_grant", k), bus.awdata_o[44:41], k);
      chk($sformatf("rr%0d_awready", k), bus.src_awready_o, 1 << k);
      chk($sformatf("rr%0d_outst", k), outstanding, k);
      cyc();
    end
    bus.src_wvalid_i = 4'b0001;
    bus.wready_i     = 1'b1;
    #1;
    chk("rr_full_awvalid", bus.awvalid_o, 0);
    chk("rr_full_outst", outstanding, 4);
    cyc();
    bus.src_wvalid_i = '0;
    #1;
    chk("rr_wrap_awvalid", bus.awvalid_o, 1);
    chk("rr_wrap_grant", bus.awdata_o[44:41], 0);
    cyc();
    chk("rr_refill_outst", outstanding, 4);
    do_reset();

    // Ordering: AW master 1 then 3, master 3 asks for W first.
    set_aw_all(4'd1);
    bus.awready_i     = 1'b1;
    bus.wready_i      = 1'b1;
    bus.src_awvalid_i = 4'b0010;
    cyc();
    bus.src_awvalid_i = 4'b1000;
    w_pl[3] = mk_w(3, 32'h30, 1'b0);
    bus.src_wvalid_i  = 4'b1000;
    #1;
    chk("ord_m3_blocked_wvalid", bus.wvalid_o, 0);
    chk("ord_m3_blocked_wready", bus.src_wready_o, 4'b0010);
    cyc();
    bus.src_awvalid_i = '0;
    for (int b = 0; b < 2; b++) begin
      w_pl[1] = mk_w(1, 32'h10 + b, b == 1);
      bus.src_wvalid_i = 4'b1010;
      #1;
      chk($sformatf("ord_m1_b%0d_wdata", b), bus.wdata_o, w_pl[1]);
      chk($sformatf("ord_m1_b%0d_wready", b), bus.src_wready_o, 4'b0010);
      cyc();
    end
    bus.src_wvalid_i = 4'b1000;
    for (int b = 0; b < 2; b++) begin
      w_pl[3] = mk_w(3, 32'h30 + b, b == 1);
      #1;
      chk($sformatf("ord_m3_b%0d_wdata", b), bus.wdata_o, w_pl[3]);
      chk($sformatf("ord_m3_b%0d_wready", b), bus.src_wready_o, 4'b1000);
      cyc();
    end
    chk("ord_outst", outstanding, 0);
    chk("ord_len_err", len_err, 0);
    do_reset();

    // Backpressure: master 0 held for 5 cycles, master 1 also waiting.
    set_aw_all(4'd0);
    bus.src_awvalid_i = 4'b0011;
    bus.awready_i     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_awvalid", k), bus.awvalid_o, 1);
      chk($sformatf("bp%0d_awdata", k), bus.awdata_o, aw_pl[0]);
      chk($sformatf("bp%0d_awready", k), bus.src_awready_o, 0);
      cyc();
    end
    bus.awready_i = 1'b1;
    #1;
    chk("bp_release", bus.src_awready_o, 4'b0001);
    cyc();
    bus.src_awvalid_i = 4'b0010;
    #1;
    chk("bp_next_grant", bus.awdata_o, aw_pl[1]);
    cyc();
    do_reset();

    // Length error: awlen 1 with wlast on the first beat.
    aw_pl[0] = mk_aw(0, 32'h40, 4'd1);
    w_pl[0]  = mk_w(0, 32'h1, 1'b1);
    bus.src_awvalid_i = 4'b0001;
    bus.awready_i     = 1'b1;
    bus.wready_i      = 1'b1;
    cyc();
    bus.src_awvalid_i = '0;
    bus.src_wvalid_i  = 4'b0001;
    #1;
    chk("lenerr_before", len_err, 0);
    cyc();
    bus.src_wvalid_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lenerr_sticky%0d", k), len_err, 1);
      cyc();
    end
    do_reset();

    // Length error: awlen 0 with wlast missing on the last beat.
    aw_pl[0] = mk_aw(0, 32'h80, 4'd0);
    w_pl[0]  = mk_w(0, 32'h2, 1'b0);
    bus.src_awvalid_i = 4'b0001;
    bus.awready_i     = 1'b1;
    bus.wready_i      = 1'b1;
    cyc();
    bus.src_awvalid_i = '0;
    bus.src_wvalid_i  = 4'b0001;
    cyc();
    w_pl[0] = mk_w(0, 32'h3, 1'b1);
    #1;
    chk("overrun_err", len_err, 1);
    chk("overrun_outst", outstanding, 1);
    cyc();
    bus.src_wvalid_i = '0;
    #1;
    chk("overrun_closed", outstanding, 0);
    do_reset();

    // Randomized traffic against a queue-level model.
    m_rr = 0; m_lock = 0; m_lock_idx = 0; m_beat = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin
      aw_on[i] = 0; w_on[i] = 0; aw_left[i] = 6; wbeat[i] = 0;
      pend_len[i] = 0;
    end
    begin
      bit done;
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
        int g, h;
        bit e_awv, e_wv, afire, wfire;
        for (int i = 0; i < N; i++) begin
          if (!aw_on[i] && aw_left[i] > 0 && ($urandom % 3) == 0) begin
            aw_on[i]    = 1;
            pend_len[i] = int'($urandom % 4);
            aw_pl[i]    = mk_aw(i, $urandom, 4'(pend_len[i]));
          end
          if (!w_on[i] && wq[i].size() > 0 && ($urandom % 2) == 0) begin
            w_on[i] = 1;
            w_pl[i] = mk_w(i, $urandom, wbeat[i] == wq[i][0]);
          end
          bus.src_awvalid_i[i] = aw_on[i];
          bus.src_wvalid_i[i]  = w_on[i];
        end
        bus.awready_i = ($urandom % 4) != 0;
        bus.wready_i  = ($urandom % 4) != 0;
        #1;
        g = -1;
        if (m_lock) g = m_lock_idx;
        else
          for (int k = 0; k < N; k++)
            if (g < 0 && bus.src_awvalid_i[(m_rr + k) % N]) g = (m_rr + k) % N;
        e_awv = (g >= 0) && (m_q.size() < D);
        afire = e_awv && bus.awready_i;
        chk("rnd_awvalid", bus.awvalid_o, e_awv);
        chk("rnd_awready", bus.src_awready_o, afire ? (1 << g) : 0);
        if (e_awv) chk("rnd_awdata", bus.awdata_o, aw_pl[g]);
        h = (m_q.size() > 0) ? m_q[0].idx : -1;
        e_wv = (h >= 0) && w_on[h];
        wfire = e_wv && bus.wready_i;
        chk("rnd_wvalid", bus.wvalid_o, e_wv);
        chk("rnd_wready", bus.src_wready_o,
            (h >= 0 && bus.wready_i) ? (1 << h) : 0);
        if (h >= 0) chk("rnd_wdata", bus.wdata_o, w_pl[h]);
        chk("rnd_outst", outstanding, m_q.size());
        chk("rnd_len_err", len_err, m_err);
        if (wfire) begin
          if (w_pl[h][0]) begin
            if (m_beat != m_q[0].len) m_err = 1;
            m_beat = 0;
            void'(m_q.pop_front());
            wbeat[h] = 0;
            void'(wq[h].pop_front());
          end else begin
            if (m_beat == m_q[0].len) m_err = 1;
            m_beat++;
            wbeat[h]++;
          end
          w_on[h] = 0;
        end
        if (afire) begin
          m_q.push_back('{g, pend_len[g]});
          wq[g].push_back(pend_len[g]);
          m_rr = (g + 1) % N;
          m_lock = 0;
          aw_on[g] = 0;
          aw_left[g]--;
        end else if (e_awv) begin
          m_lock = 1;
          m_lock_idx = g;
        end
        done = (m_q.size() == 0);
        for (int i = 0; i < N; i++)
          if (aw_left[i] != 0 || aw_on[i] || w_on[i]) done = 0;
        cyc();
      end
      chk("rnd_completed", done, 1);
    end
    chk("rnd_final_len_err", len_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
